// File: rtl/irst_isa_pkg.sv
// Shared ISA constants, randomizer modes and control-FSM states for the
// IRST-MIPS instruction randomizer.
package irst_isa_pkg;

   localparam logic [3:0] OPC_NOP  = 4'd0;
   localparam logic [3:0] OPC_ADD  = 4'd1;
   localparam logic [3:0] OPC_SUB  = 4'd2;
   localparam logic [3:0] OPC_AND  = 4'd3;
   localparam logic [3:0] OPC_OR   = 4'd4;
   localparam logic [3:0] OPC_XOR  = 4'd5;
   localparam logic [3:0] OPC_SLL  = 4'd6;
   localparam logic [3:0] OPC_SRL  = 4'd7;
   localparam logic [3:0] OPC_SLT  = 4'd8;
   localparam logic [3:0] OPC_ADDI = 4'd9;
   localparam logic [3:0] OPC_LD   = 4'd10;
   localparam logic [3:0] OPC_ST   = 4'd11;
   localparam logic [3:0] OPC_BZ   = 4'd12;

   localparam logic [15:0] MASK_RR  = 16'h0FF8;
   localparam logic [15:0] MASK_IMM = 16'h0FFF;
   localparam logic [15:0] MASK_BR  = 16'h01F8;

   // Feedback taps at bits 15, 13, 12, 10.
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef enum logic [1:0] {
      MODE_BYPASS    = 2'd0,
      MODE_FIELD     = 2'd1,
      MODE_OPCODE    = 2'd2,
      MODE_FIELD_ALT = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   function automatic logic [15:0] opc_mask(input logic [3:0] opc);
      logic [15:0] m;
      m = '0;
      if (opc <= OPC_SLT)      m = MASK_RR;
      else if (opc <= OPC_ST)  m = MASK_IMM;
      else if (opc == OPC_BZ)  m = MASK_BR;
      return m;
   endfunction

endpackage

// File: rtl/rand_lfsr16.sv
// Seedable 16-bit Fibonacci LFSR; a zero seed is replaced by the default
// so the register can never lock up at all-zeros.
module rand_lfsr16
   import irst_isa_pkg::*;
#(
   parameter int unsigned  DATA_W    = 16,
   parameter logic [15:0]  SEED_DFLT = 16'hACE1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [DATA_W-1:0] seed,
   input  logic              advance,
   output logic [DATA_W-1:0] value
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value <= SEED_DFLT;
      end else if (load) begin
         value <= (seed == '0) ? SEED_DFLT : seed;
      end else if (advance) begin
         value <= {value[DATA_W-2:0], ^(value & LFSR_TAPS)};
      end
   end

endmodule

// File: rtl/rand_inst_stream.sv
// Streaming instruction randomizer: masks template operand fields (and
// optionally the opcode) with LFSR bits and guards a protected register.
module rand_inst_stream
   import irst_isa_pkg::*;
#(
   parameter int unsigned      DATA_W    = 16,
   parameter int unsigned      REG_W     = 3,
   parameter logic [REG_W-1:0] PROT_REG  = 3'b000,
   parameter logic [REG_W-1:0] SUBST_REG = 3'b001,
   parameter logic [15:0]      SEED_DFLT = 16'hACE1,
   parameter int unsigned      CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        mode,
   input  logic              seed_load,
   input  logic [DATA_W-1:0] seed,
   input  logic              start,
   input  logic [CNT_W-1:0]  len,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_inst,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_inst,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  beat_cnt
);

   state_e             state, state_nxt;
   logic [CNT_W-1:0]   len_q;
   logic [DATA_W-1:0]  lfsr;
   logic               accept;
   logic               out_free;

   function automatic logic [DATA_W-1:0] xform(
      input logic [DATA_W-1:0] inst,
      input logic [DATA_W-1:0] r,
      input logic [1:0]        m
   );
      logic [3:0]        o;
      logic [DATA_W-1:0] mask;
      logic [DATA_W-1:0] t;
      o = inst[DATA_W-1 -: 4];
      if (m == MODE_OPCODE) begin
         // Fold opcodes 13-15 back onto the legal 9-11 range.
         o = r[DATA_W-1 -: 4];
         if (o > OPC_BZ) o = o - 4'd4;
      end
      mask = opc_mask(o);
      t = ({o, inst[DATA_W-5:0]} & ~mask) | (r & mask);
      if (o != OPC_BZ && t[DATA_W-5 -: REG_W] == PROT_REG)
         t[DATA_W-5 -: REG_W] = SUBST_REG;
      if (m == MODE_BYPASS) t = inst;
      return t;
   endfunction

   assign out_free = !out_valid || out_ready;
   assign in_ready = (state == RUN) && out_free;
   assign accept   = in_valid && in_ready;
   assign busy     = (state != IDLE);
   assign done     = (state == DONE);

   rand_lfsr16 #(
      .DATA_W    (DATA_W),
      .SEED_DFLT (SEED_DFLT)
   ) u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .load    (seed_load),
      .seed    (seed),
      .advance (accept),
      .value   (lfsr)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (start) state_nxt = (len == '0) ? DONE : RUN;
         RUN:   if (accept && (beat_cnt + CNT_W'(1)) == len_q) state_nxt = DRAIN;
         DRAIN: if (out_free) state_nxt = DONE;
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_q    <= '0;
         beat_cnt <= '0;
      end else if (state == IDLE && start) begin
         len_q    <= len;
         beat_cnt <= '0;
      end else if (accept) begin
         beat_cnt <= beat_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_inst  <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_inst  <= xform(in_inst, lfsr, mode);
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rand_inst_stream.sv
// Scenario bench for rand_inst_stream with a scoreboard of expected output
// beats, checked by a monitor whenever an output beat is consumed.
module tb_rand_inst_stream;

   logic        clk;
   logic        rst;
   logic [1:0]  mode;
   logic        seed_load;
   logic [15:0] seed;
   logic        start;
   logic [15:0] len;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_inst;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_inst;
   logic        busy;
   logic        done;
   logic [15:0] beat_cnt;

   int          vectors;
   int          miscompares;
   logic [15:0] sb[$];
   logic [15:0] model_lfsr;

   rand_inst_stream #(
      .DATA_W    (16),
      .REG_W     (3),
      .PROT_REG  (3'b000),
      .SUBST_REG (3'b001),
      .SEED_DFLT (16'hACE1),
      .CNT_W     (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .seed_load (seed_load),
      .seed      (seed),
      .start     (start),
      .len       (len),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_inst   (in_inst),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_inst  (out_inst),
      .busy      (busy),
      .done      (done),
      .beat_cnt  (beat_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] lfsr_next(input logic [15:0] r);
      return {r[14:0], r[15] ^ r[13] ^ r[12] ^ r[10]};
   endfunction

   function automatic logic [15:0] ref_f(input logic [15:0] inst,
                                         input logic [15:0] r,
                                         input logic [1:0]  m);
      logic [3:0]  o;
      logic [15:0] mask;
      logic [15:0] t;
      if (m == 2'd0) return inst;
      o = (m == 2'd2) ? r[15:12] : inst[15:12];
      if (m == 2'd2 && o > 4'd12) o = o - 4'd4;
      if (o <= 4'd8)       mask = 16'h0FF8;
      else if (o <= 4'd11) mask = 16'h0FFF;
      else if (o == 4'd12) mask = 16'h01F8;
      else                 mask = 16'h0000;
      t = ({o, inst[11:0]} & ~mask) | (r & mask);
      if (o != 4'd12 && t[11:9] == 3'b000) t[11:9] = 3'b001;
      return t;
   endfunction

   // Output monitor: pops the scoreboard on every consumed beat.
   initial begin
      logic [15:0] exp_v;
      forever begin
         @(negedge clk);
         #4;
         if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            vectors++;
            if (sb.size() == 0) begin
               miscompares++;
               $display("FAIL sb_unexpected: out_inst=%h with empty scoreboard", out_inst);
            end else begin
               exp_v = sb.pop_front();
               if (out_inst !== exp_v) begin
                  miscompares++;
                  $display("FAIL sb_out_inst: got %h expected %h", out_inst, exp_v);
               end
            end
         end
      end
   end

   // All stimulus tasks start and end on a falling edge.
   task automatic load_seed(input logic [15:0] s);
      seed_load = 1'b1;
      seed      = s;
      @(negedge clk);
      seed_load = 1'b0;
      model_lfsr = (s == 16'h0000) ? 16'hACE1 : s;
   endtask

   task automatic start_run(input logic [15:0] l);
      start = 1'b1;
      len   = l;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send(input logic [15:0] inst, input logic [1:0] m,
                       input logic [15:0] exp_v);
      bit taken;
      taken    = 1'b0;
      in_valid = 1'b1;
      in_inst  = inst;
      mode     = m;
      for (int i = 0; i < 50 && !taken; i++) begin
         #4;
         if (in_ready === 1'b1) begin
            taken = 1'b1;
            sb.push_back(exp_v);
            model_lfsr = lfsr_next(model_lfsr);
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      if (!taken) begin
         vectors++;
         miscompares++;
         $display("FAIL send_timeout: inst %h never accepted", inst);
      end
   endtask

   task automatic finish_run(input string name, input logic [15:0] exp_cnt);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         #4;
         if (done === 1'b1) seen = 1'b1;
         else @(negedge clk);
      end
      vectors++;
      if (!seen) begin
         miscompares++;
         $display("FAIL %s_done: got no done pulse expected one", name);
      end
      vectors++;
      if (beat_cnt !== exp_cnt) begin
         miscompares++;
         $display("FAIL %s_beat_cnt: got %0d expected %0d", name, beat_cnt, exp_cnt);
      end
      @(negedge clk);
      #4;
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL %s_idle: got done=%b busy=%b expected 0 0", name, done, busy);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      #4;
      vectors++;
      if ({out_valid, busy, done, in_ready} !== 4'b0000 || out_inst !== 16'h0000 ||
          beat_cnt !== 16'h0000) begin
         miscompares++;
         $display("FAIL reset_outputs: got v=%b b=%b d=%b r=%b inst=%h cnt=%h expected all 0",
                  out_valid, busy, done, in_ready, out_inst, beat_cnt);
      end
      vectors++;
      if (dut.u_lfsr.value !== 16'hACE1) begin
         miscompares++;
         $display("FAIL reset_lfsr: got %h expected ace1", dut.u_lfsr.value);
      end
      @(negedge clk);
      rst = 1'b0;
      model_lfsr = 16'hACE1;
   endtask

   task automatic test_bypass();
      out_ready = 1'b1;
      start_run(16'd2);
      send(16'h1234, 2'd0, 16'h1234);
      #4;
      vectors++;
      if (out_valid !== 1'b1 || out_inst !== 16'h1234) begin
         miscompares++;
         $display("FAIL bypass_latency: got v=%b inst=%h expected 1 1234", out_valid, out_inst);
      end
      @(negedge clk);
      send(16'hA000, 2'd0, 16'hA000);
      finish_run("bypass", 16'd2);
   endtask

   task automatic test_field_masks();
      load_seed(16'hFFFF);
      start_run(16'd1);
      send(16'h1000, 2'd1, 16'h1FF8);
      finish_run("field_add", 16'd1);
      vectors++;
      if (dut.u_lfsr.value !== 16'hFFFE) begin
         miscompares++;
         $display("FAIL lfsr_advance: got %h expected fffe", dut.u_lfsr.value);
      end
      load_seed(16'h0001);
      start_run(16'd1);
      send(16'hA000, 2'd1, 16'hA201);
      finish_run("field_ld_prot", 16'd1);
      load_seed(16'h0001);
      start_run(16'd1);
      send(16'hC000, 2'd1, 16'hC000);
      finish_run("field_bz", 16'd1);
   endtask

   task automatic test_opcode_mode();
      load_seed(16'hFFFF);
      start_run(16'd1);
      send(16'h0000, 2'd2, 16'hBFFF);
      finish_run("opcode", 16'd1);
      load_seed(16'h0000);
      vectors++;
      if (dut.u_lfsr.value !== 16'hACE1) begin
         miscompares++;
         $display("FAIL zero_seed: got %h expected ace1", dut.u_lfsr.value);
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] exp0;
      logic [15:0] held;
      load_seed(16'h1234);
      out_ready = 1'b0;
      start_run(16'd3);
      exp0 = ref_f(16'h3456, model_lfsr, 2'd1);
      send(16'h3456, 2'd1, exp0);
      held     = model_lfsr;
      in_valid = 1'b1;
      in_inst  = 16'h7000;
      for (int i = 0; i < 4; i++) begin
         #4;
         vectors++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_inst !== exp0 ||
             dut.u_lfsr.value !== held) begin
            miscompares++;
            $display("FAIL bp_hold: got rdy=%b v=%b inst=%h lfsr=%h expected 0 1 %h %h",
                     in_ready, out_valid, out_inst, dut.u_lfsr.value, exp0, held);
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      send(16'h7000, 2'd1, ref_f(16'h7000, model_lfsr, 2'd1));
      send(16'hB5A5, 2'd1, ref_f(16'hB5A5, model_lfsr, 2'd1));
      finish_run("backpressure", 16'd3);
   endtask

   task automatic test_len_zero();
      start_run(16'd0);
      #4;
      vectors++;
      if (done !== 1'b1 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL len0_done: got done=%b busy=%b expected 1 1", done, busy);
      end
      @(negedge clk);
      #4;
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0 || beat_cnt !== 16'd0) begin
         miscompares++;
         $display("FAIL len0_after: got done=%b busy=%b cnt=%0d expected 0 0 0",
                  done, busy, beat_cnt);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_run();
      load_seed(16'h5555);
      out_ready = 1'b0;
      start_run(16'd4);
      send(16'h2468, 2'd1, ref_f(16'h2468, model_lfsr, 2'd1));
      #2;
      vectors++;
      if (out_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL midrst_pre: got out_valid=%b expected 1", out_valid);
      end
      rst = 1'b1;
      #1;
      vectors++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || dut.u_lfsr.value !== 16'hACE1 ||
          beat_cnt !== 16'd0 || in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL midrst: got v=%b busy=%b lfsr=%h cnt=%0d rdy=%b expected 0 0 ace1 0 0",
                  out_valid, busy, dut.u_lfsr.value, beat_cnt, in_ready);
      end
      sb.delete();
      @(negedge clk);
      rst        = 1'b0;
      out_ready  = 1'b1;
      model_lfsr = 16'hACE1;
   endtask

   task automatic test_back_to_back();
      start_run(16'd3);
      send(16'h5A00, 2'd3, ref_f(16'h5A00, model_lfsr, 2'd3));
      send(16'h9123, 2'd1, ref_f(16'h9123, model_lfsr, 2'd1));
      send(16'h4321, 2'd2, ref_f(16'h4321, model_lfsr, 2'd2));
      finish_run("b2b", 16'd3);
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL sb_leftover: got %0d pending expected 0", sb.size());
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      mode        = 2'd0;
      seed_load   = 1'b0;
      seed        = 16'h0000;
      start       = 1'b0;
      len         = 16'd0;
      in_valid    = 1'b0;
      in_inst     = 16'h0000;
      out_ready   = 1'b0;
      model_lfsr  = 16'hACE1;
      @(negedge clk);
      test_reset();
      test_bypass();
      test_field_masks();
      test_opcode_mode();
      test_backpressure();
      test_len_zero();
      test_reset_mid_run();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/rand_inst_stream.md
Name: rand_inst_stream

Overview:
- Streaming, parametrised instruction randomizer for the 16-bit IRST-MIPS test-generation path.
- Accepts template instructions over a valid/ready stream and randomizes operand fields with an internal, seedable LFSR. In one mode it also randomizes the opcode.
- Protects a designated processor register from being written, and runs for a programmed number of beats under a small control FSM.
- Sits between the instruction template source and the instruction memory loader.

Parameters:
- DATA_W, 16, instruction and LFSR width (fixed 16 in this generation; masks are defined for 16).
- REG_W, 3, register-field width; destination field is [DATA_W-5 -: REG_W] = [11:9].
- PROT_REG, 3'b000, destination register that must never be written.
- SUBST_REG, 3'b001, replacement for PROT_REG.
- SEED_DFLT, 16'hACE1, LFSR value after reset and substitute when a zero seed is loaded.
- CNT_W, 16, width of the beat-length and beat-count registers.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- mode  in  2  0=bypass, 1=field randomize, 2=opcode+field randomize, 3=treated as 1
- seed_load  in  1  load LFSR from seed this cycle
- seed  in  DATA_W  LFSR seed
- start  in  1  begin a run of len beats (sampled only in IDLE)
- len  in  CNT_W  beats in the run
- in_valid  in  1  template valid
- in_ready  out  1  template accepted when in_valid&in_ready
- in_inst  in  DATA_W  template instruction
- out_valid  out  1  randomized instruction valid
- out_ready  in  1  downstream ready
- out_inst  out  DATA_W  randomized instruction
- busy  out  1  FSM not IDLE
- done  out  1  one-cycle pulse at end of run
- beat_cnt  out  CNT_W  beats accepted in current/last run

Behaviour:
- Reset values: state=IDLE, lfsr=SEED_DFLT, out_valid=0, out_inst=0, beat_cnt=0, done=0, busy=0, in_ready=0.
- FSM IDLE -> RUN on start.
  - If len==0 at start: IDLE -> DONE directly.
  - RUN -> DRAIN when the accepted beat makes beat_cnt==len.
  - DRAIN -> DONE when output register empty (out_valid==0, or out_valid&out_ready).
  - DONE -> IDLE unconditionally after 1 cycle; done=1 only in DONE.
- start clears beat_cnt to 0 and latches len. start outside IDLE is ignored.
- in_ready = (state==RUN) & (!out_valid | out_ready). Zero in IDLE, DRAIN and DONE.
- Latency: accepted beat appears on out_inst the next cycle. The single output register holds until out_valid&out_ready; full throughput when out_ready=1.
- The LFSR value used for a beat is the current value. The LFSR advances once per accepted beat:
  - next = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
- seed_load is allowed in any state and has priority over advance. seed==0 loads SEED_DFLT. A beat accepted in the same cycle as seed_load uses the pre-load LFSR value.
- Transform f(inst, r), with opc = inst[15:12]:
  - mode 0: out = inst; no protection applied.
  - mode 1/3: mask by opc.
    - 0-8 -> MASK_RR 16'h0FF8
    - 9-11 -> MASK_IMM 16'h0FFF
    - 12 (BZ) -> MASK_BR 16'h01F8
    - 13-15 -> 0
    - t = (inst & ~mask) | (r & mask)
  - mode 2: opcode o = r[15:12]; if o>12 then o = o-4. Then t = {o, inst[11:0]}, and mask and merge per o as in mode 1.
  - Protection (modes 1-3): if t[15:12]!=BZ and t[11:9]==PROT_REG, then t[11:9]=SUBST_REG.
- beat_cnt increments per accepted beat. It holds after the run and is cleared only by start or rst.
- rst mid-run: immediate return to reset values; an in-flight output beat is discarded.
- mode may change between beats; it is sampled on the accepting cycle.

Decomposition:
- Package irst_isa_pkg:
  - opcode constants NOP..BZ
  - MASK_RR/MASK_IMM/MASK_BR
  - mode encodings
  - FSM state enum (IDLE, RUN, DRAIN, DONE)
  - LFSR tap constant
- Sub-module rand_lfsr16 (seed/load/advance, zero-seed guard).
- The transform stays inline as a combinational function.

Test Plan:
- Reset, mode=0, start len=2, in_inst 16'h1234, 16'hA000, out_ready=1 -> out_inst 16'h1234 then 16'hA000 one cycle after each accept; done pulse; beat_cnt=2.
- seed_load seed=16'hFFFF, mode=1, len=1, in_inst 16'h1000 (ADD) -> out_inst 16'h1FF8; LFSR next = 16'hFFFE.
- seed=16'h0001, mode=1, in_inst 16'hA000 (LD) -> 16'hA201 (r0 dest replaced by r1). Same seed, in_inst 16'hC000 (BZ) -> 16'hC000 (no substitution).
- seed=16'hFFFF, mode=2, in_inst 16'h0000 -> opcode 15->11, out_inst 16'hBFFF. seed_load seed=0 -> LFSR reads SEED_DFLT.
- Backpressure: len=3, out_ready=0 for 4 cycles -> in_ready=0 after first accept, out_inst stable, no LFSR advance. Then release -> 3 beats, DRAIN, done.
- start with len=0 -> done pulse 1 cycle after start, beat_cnt=0. Assert rst mid-run with out_valid=1 -> out_valid=0, busy=0, lfsr=16'hACE1 immediately.
